// File: rtl/z_multdiv_iter.sv
// z_multdiv_iter: iterative signed multiply / divide, one bit per clock.
// Ports:
//   clk, clrn (async active-low reset)
//   data_operandA/B   two's complement operands, captured at start
//   ctrl_MULT/DIV     start requests, ignored while busy (MULT wins on tie)
//   data_result       low WIDTH product bits or truncated quotient
//   data_exception    overflow / divide-by-zero, qualified by data_resultRDY
//   data_resultRDY    one-cycle completion pulse
//   busy              operation in progress
// Build option: Z_MULTDIV_EARLY_DIV0_EN finishes a divide-by-zero after
// one RUN cycle instead of the full WIDTH iterations.
module z_multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   ONE_W  = 1;
    localparam logic [2*WIDTH-1:0] ONE_2W = 1;
    // |product| limit: 2^(WIDTH-1)
    localparam logic [2*WIDTH-1:0] LIM = ONE_2W << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   tok_q, tok_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic               neg_q, neg_d;
    logic               div_q, div_d;
    logic               divz_q, divz_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               start, is_div;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH:0]     div_tr;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic               mul_ovf;
    logic               last;
    logic               early_exit;

    assign a_mag = data_operandA[WIDTH-1] ? (~data_operandA + ONE_W)
                                          : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? (~data_operandB + ONE_W)
                                          : data_operandB;

    assign start  = ctrl_MULT | ctrl_DIV;
    assign is_div = ctrl_DIV & ~ctrl_MULT;

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}; shift left,
    // trial-subtract divisor, keep the difference when it did not borrow.
    assign div_sh  = {acc_q, 1'b0};
    assign div_tr  = div_sh[2*WIDTH:WIDTH] - {1'b0, opd_q};
    assign div_nxt = div_tr[WIDTH]
                   ? div_sh[2*WIDTH-1:0]
                   : {div_tr[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

    assign step = div_q ? div_nxt : mul_nxt;

    // Sign fix-up on the value produced by the final iteration.
    assign prod_s  = neg_q ? (~step + ONE_2W) : step;
    assign quo_s   = neg_q ? (~step[WIDTH-1:0] + ONE_W) : step[WIDTH-1:0];
    assign mul_ovf = neg_q ? (step > LIM) : (step >= LIM);

    assign last = tok_q[WIDTH-1] & (cnt_q == CW'(1));

`ifdef Z_MULTDIV_EARLY_DIV0_EN
    assign early_exit = divz_q;
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tok_d   = tok_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        neg_d   = neg_q;
        div_d   = div_q;
        divz_d  = divz_q;
        res_d   = res_q;
        exc_d   = exc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    tok_d   = ONE_W;
                    cnt_d   = CW'(WIDTH);
                    div_d   = is_div;
                    neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    divz_d  = is_div & (data_operandB == '0);
                    if (is_div) begin
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                        opd_d = b_mag;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                        opd_d = a_mag;
                    end
                end
            end
            RUN: begin
                if (early_exit) begin
                    state_d = DONE;
                    tok_d   = '0;
                    cnt_d   = '0;
                    res_d   = '0;
                    exc_d   = 1'b1;
                end else begin
                    acc_d = step;
                    tok_d = tok_q << 1;
                    cnt_d = cnt_q - CW'(1);
                    if (last) begin
                        state_d = DONE;
                        if (!div_q) begin
                            res_d = prod_s[WIDTH-1:0];
                            exc_d = mul_ovf;
                        end else if (divz_q) begin
                            res_d = '0;
                            exc_d = 1'b1;
                        end else begin
                            // only -2^(W-1) / -1 yields a positive 2^(W-1)
                            res_d = quo_s;
                            exc_d = ~neg_q & step[WIDTH-1];
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            tok_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            neg_q   <= 1'b0;
            div_q   <= 1'b0;
            divz_q  <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tok_q   <= tok_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            neg_q   <= neg_d;
            div_q   <= div_d;
            divz_q  <= divz_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_z_multdiv_iter.sv
// Bench for z_multdiv_iter: directed vectors, queued expectations,
// independent monitor checking result, exception and completion cycle.
module tb_z_multdiv_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clrn = 1'b0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         cm = 1'b0;
    logic         cd = 1'b0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    z_multdiv_iter #(.WIDTH(W)) dut (
        .clk           (clk),
        .clrn          (clrn),
        .data_operandA (opa),
        .data_operandB (opb),
        .ctrl_MULT     (cm),
        .ctrl_DIV      (cd),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        int           cyc;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int passed = 0;
    logic [W-1:0] last_res = '0;
    logic         last_exc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops one expectation per completion pulse.
    always @(negedge clk) begin
        if (clrn && data_resultRDY) begin
            if (q.size() == 0) begin
                chk("spurious_rdy", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", data_result, e.res);
                chk("exception", data_exception, e.exc);
                chk("rdy_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge following edge S.
    task automatic start_op(input bit div, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] res,
                            input logic exc, input bit push, output int s);
        int n;
        int lat;
        exp_t e;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 64'd1, 64'd0);
        chk("hold_result", data_result, last_res);
        chk("hold_exc", data_exception, last_exc);
        opa = a;
        opb = b;
        cm  = !div;
        cd  = div;
        s   = cyc + 1;
        lat = W;
`ifdef Z_MULTDIV_EARLY_DIV0_EN
        if (div && b == '0) lat = 1;
`endif
        if (push) begin
            e.res = res;
            e.exc = exc;
            e.cyc = s + lat;
            q.push_back(e);
            last_res = res;
            last_exc = exc;
        end
        @(negedge clk);
        cm  = 1'b0;
        cd  = 1'b0;
        opa = $urandom;
        opb = $urandom;
        chk("busy_run", busy, 1);
    endtask

    initial begin
        int s;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", data_resultRDY, 0);
        chk("rst_result", data_result, 0);
        chk("rst_exc", data_exception, 0);
        clrn = 1'b1;

        start_op(0, 32'd7, 32'd6, 32'd42, 0, 1, s);
        start_op(0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 0, 1, s);
        start_op(0, 32'h00010000, 32'h00010000, 32'd0, 1, 1, s);
        start_op(0, 32'h80000000, 32'd1, 32'h80000000, 0, 1, s);
        start_op(0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1, s);
        start_op(1, 32'd100, 32'd7, 32'd14, 0, 1, s);
        start_op(1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 0, 1, s);
        start_op(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1, s);
        start_op(1, 32'd5, 32'd0, 32'd0, 1, 1, s);
        start_op(1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 1, s);

        // Start request while busy must be ignored.
        start_op(0, 32'd7, 32'd6, 32'd42, 0, 1, s);
        while (cyc < s + 9) @(negedge clk);
        opa = 32'd100;
        opb = 32'd7;
        cd  = 1'b1;
        @(negedge clk);
        cd  = 1'b0;
        chk("busy_ignore", busy, 1);

        // Abort mid-run with reset.
        start_op(0, 32'd9, 32'd9, 32'd81, 0, 0, s);
        while (cyc < s + 15) @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", data_result, 0);
        chk("abort_exc", data_exception, 0);
        chk("abort_rdy", data_resultRDY, 0);
        last_res = '0;
        last_exc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;

        start_op(0, 32'd2, 32'd3, 32'd6, 0, 1, s);

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        repeat (40) @(negedge clk);
        chk("final_idle", busy, 0);
        chk("final_result", data_result, last_res);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
